// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).
// bcd/overflow hold the last result while a new conversion runs.
module bin2bcd_seq #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {IDLE, CONV} state_t;

    state_t                state, state_nx;
    logic [WIDTH-1:0]      sh, sh_nx, sh_sh;
    logic [4*DIGITS-1:0]   acc, acc_nx, acc_sh, adj;
    logic                  ovf, ovf_nx, ovf_sh;
    logic [CW-1:0]         cnt, cnt_nx;
    logic [4*DIGITS-1:0]   bcd_nx;
    logic                  overflow_nx, done_nx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            sh       <= '0;
            acc      <= '0;
            ovf      <= 1'b0;
            cnt      <= '0;
            bcd      <= '0;
            overflow <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_nx;
            sh       <= sh_nx;
            acc      <= acc_nx;
            ovf      <= ovf_nx;
            cnt      <= cnt_nx;
            bcd      <= bcd_nx;
            overflow <= overflow_nx;
            done     <= done_nx;
        end
    end

    assign busy = (state == CONV);

    always_comb begin
        // Add-3 on the pre-shift digits, then shift {acc,sh} left by one.
        adj = acc;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (acc[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
        end
        sh_sh  = sh << 1;
        acc_sh = {adj[4*DIGITS-2:0], sh[WIDTH-1]};
        // A bit leaving the top digit means the value no longer fits in DIGITS.
        ovf_sh = ovf | adj[4*DIGITS-1];

        state_nx    = state;
        sh_nx       = sh;
        acc_nx      = acc;
        ovf_nx      = ovf;
        cnt_nx      = cnt;
        bcd_nx      = bcd;
        overflow_nx = overflow;
        done_nx     = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    sh_nx    = bin;
                    acc_nx   = '0;
                    ovf_nx   = 1'b0;
                    cnt_nx   = CW'(WIDTH);
                    state_nx = CONV;
                end
            end
            CONV: begin
                sh_nx  = sh_sh;
                acc_nx = acc_sh;
                ovf_nx = ovf_sh;
                cnt_nx = cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    done_nx     = 1'b1;
                    state_nx    = IDLE;
                    overflow_nx = ovf_sh;
                    bcd_nx      = ovf_sh ? '1 : acc_sh;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Bench for bin2bcd_seq: a 5-digit and a 4-digit instance, expected results
// queued at launch from a decimal model and compared when done pulses.
module tb_bin2bcd_seq;

    localparam int W = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start5 = 1'b0, start4 = 1'b0;
    logic [15:0] bin5 = '0, bin4 = '0;
    logic [19:0] bcd5;
    logic [15:0] bcd4;
    logic        busy5, done5, ovf5, busy4, done4, ovf4;

    int checks = 0;
    int errors = 0;

    logic [20:0] q5[$];
    logic [20:0] q4[$];

    always #5 clk = ~clk;

    bin2bcd_seq #(.WIDTH(16), .DIGITS(5)) dut5 (
        .clk(clk), .rst(rst), .start(start5), .bin(bin5),
        .bcd(bcd5), .busy(busy5), .done(done5), .overflow(ovf5)
    );

    bin2bcd_seq #(.WIDTH(16), .DIGITS(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .bin(bin4),
        .bcd(bcd4), .busy(busy4), .done(done4), .overflow(ovf4)
    );

    // Expected {overflow, bcd[19:0]} computed by decimal division.
    function automatic logic [20:0] model(input int unsigned v, input int unsigned d);
        logic [20:0] r;
        int unsigned lim;
        int unsigned x;
        r = '0;
        lim = 1;
        x = v;
        for (int unsigned i = 0; i < d; i++) lim = lim * 10;
        if (v >= lim) begin
            r[20] = 1'b1;
            for (int unsigned i = 0; i < d; i++) r[4*i +: 4] = 4'hF;
        end else begin
            for (int unsigned i = 0; i < d; i++) begin
                r[4*i +: 4] = 4'(x % 10);
                x = x / 10;
            end
        end
        return r;
    endfunction

    // Drive one accepted start on dut5; returns 1 ns after the accepting edge.
    task automatic launch5(input logic [15:0] v);
        start5 = 1'b1;
        bin5   = v;
        q5.push_back(model(v, 5));
        @(posedge clk);
        #1 start5 = 1'b0;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        checks++;
        if ({bcd5, busy5, done5, ovf5} !== 23'd0) begin
            errors++;
            $display("FAIL reset5 got bcd=%h busy=%b done=%b ovf=%b want all 0", bcd5, busy5, done5, ovf5);
        end
        checks++;
        if ({bcd4, busy4, done4, ovf4} !== 19'd0) begin
            errors++;
            $display("FAIL reset4 got bcd=%h busy=%b done=%b ovf=%b want all 0", bcd4, busy4, done4, ovf4);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({bcd5, busy5, done5, ovf5} !== 23'd0) begin
            errors++;
            $display("FAIL post_reset5 got bcd=%h busy=%b done=%b want all 0", bcd5, busy5, done5);
        end
    endtask

    task automatic test_single;
        logic [20:0] e;
        launch5(16'd12345);
        for (int c = 0; c <= W + 2; c++) begin
            @(negedge clk);
            checks++;
            if (busy5 !== (c < W)) begin
                errors++;
                $display("FAIL single_busy c=%0d got %b want %b", c, busy5, (c < W));
            end
            checks++;
            if (done5 !== (c == W)) begin
                errors++;
                $display("FAIL single_done c=%0d got %b want %b", c, done5, (c == W));
            end
            if (done5 === 1'b1 && q5.size() > 0) begin
                e = q5.pop_front();
                checks++;
                if ({ovf5, bcd5} !== e) begin
                    errors++;
                    $display("FAIL single_result got %h want %h", {ovf5, bcd5}, e);
                end
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [20:0] e;
        int dones = 0;
        start5 = 1'b1;
        bin5   = 16'd0;
        q5.push_back(model(0, 5));
        q5.push_back(model(65535, 5));
        @(posedge clk);
        #1 bin5 = 16'd65535;
        for (int c = 0; c <= 2 * W + 4; c++) begin
            @(negedge clk);
            if (c == W + 1) start5 = 1'b0;
            checks++;
            if (done5 !== (c == W || c == 2 * W + 1)) begin
                errors++;
                $display("FAIL b2b_done c=%0d got %b want %b", c, done5, (c == W || c == 2 * W + 1));
            end
            if (c == W + 1) begin
                checks++;
                if (busy5 !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_restart_busy got %b want 1", busy5);
                end
            end
            if (done5 === 1'b1) begin
                dones++;
                if (q5.size() > 0) begin
                    e = q5.pop_front();
                    checks++;
                    if ({ovf5, bcd5} !== e) begin
                        errors++;
                        $display("FAIL b2b_result got %h want %h", {ovf5, bcd5}, e);
                    end
                end
            end
        end
        checks++;
        if (dones != 2) begin
            errors++;
            $display("FAIL b2b_done_count got %0d want 2", dones);
        end
    endtask

    task automatic test_overflow4;
        int unsigned vals[3] = '{9999, 10000, 42};
        logic [20:0] e;
        bit seen;
        foreach (vals[j]) begin
            start4 = 1'b1;
            bin4   = 16'(vals[j]);
            q4.push_back(model(vals[j], 4));
            @(posedge clk);
            #1 start4 = 1'b0;
            seen = 1'b0;
            for (int c = 0; c <= W + 3; c++) begin
                @(negedge clk);
                if (done4 === 1'b1 && !seen) begin
                    seen = 1'b1;
                    checks++;
                    if (c != W) begin
                        errors++;
                        $display("FAIL ovf4_latency v=%0d got %0d want %0d", vals[j], c, W);
                    end
                    e = q4.pop_front();
                    checks++;
                    if ({ovf4, 4'h0, bcd4} !== e) begin
                        errors++;
                        $display("FAIL ovf4_result v=%0d got ovf=%b bcd=%h want %h", vals[j], ovf4, bcd4, e);
                    end
                end
            end
            checks++;
            if (!seen) begin
                errors++;
                $display("FAIL ovf4_timeout v=%0d got no done want done", vals[j]);
                void'(q4.pop_front());
            end
        end
    endtask

    task automatic test_ignore_start;
        logic [20:0] e;
        launch5(16'd12345);
        for (int c = 0; c <= W + 2; c++) begin
            @(negedge clk);
            if (c == 5) begin start5 = 1'b1; bin5 = 16'd999; end
            if (c == 6) start5 = 1'b0;
            checks++;
            if (busy5 !== (c < W) || done5 !== (c == W)) begin
                errors++;
                $display("FAIL ignore_busy_done c=%0d got busy=%b done=%b", c, busy5, done5);
            end
            if (done5 === 1'b1 && q5.size() > 0) begin
                e = q5.pop_front();
                checks++;
                if ({ovf5, bcd5} !== e) begin
                    errors++;
                    $display("FAIL ignore_result got %h want %h", {ovf5, bcd5}, e);
                end
            end
        end
    endtask

    task automatic test_reset_abort;
        logic [20:0] e;
        launch5(16'd777);
        for (int c = 0; c <= W + 1; c++) begin
            @(negedge clk);
            if (done5 === 1'b1 && q5.size() > 0) begin
                e = q5.pop_front();
                checks++;
                if ({ovf5, bcd5} !== e) begin
                    errors++;
                    $display("FAIL abort_first got %h want %h", {ovf5, bcd5}, e);
                end
            end
        end
        launch5(16'd500);
        void'(q5.pop_back());
        repeat (8) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({bcd5, busy5, done5, ovf5} !== 23'd0) begin
            errors++;
            $display("FAIL abort_immediate got bcd=%h busy=%b done=%b ovf=%b want all 0", bcd5, busy5, done5, ovf5);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (done5 !== 1'b0 || bcd5 !== 20'h0) begin
                errors++;
                $display("FAIL abort_hold got done=%b bcd=%h want 0/0", done5, bcd5);
            end
        end
        rst = 1'b0;
        @(negedge clk);
        launch5(16'd31);
        for (int c = 0; c <= W + 1; c++) begin
            @(negedge clk);
            if (done5 === 1'b1 && q5.size() > 0) begin
                e = q5.pop_front();
                checks++;
                if ({ovf5, bcd5} !== e) begin
                    errors++;
                    $display("FAIL abort_fresh got %h want %h", {ovf5, bcd5}, e);
                end
            end
        end
    endtask

    task automatic test_hold;
        logic [20:0] e;
        logic [20:0] prev;
        prev = model(1234, 5);
        launch5(16'd1234);
        for (int c = 0; c <= W + 1; c++) begin
            @(negedge clk);
            if (done5 === 1'b1 && q5.size() > 0) begin
                e = q5.pop_front();
                checks++;
                if ({ovf5, bcd5} !== e) begin
                    errors++;
                    $display("FAIL hold_first got %h want %h", {ovf5, bcd5}, e);
                end
            end
        end
        launch5(16'd4321);
        for (int c = 0; c <= W; c++) begin
            @(negedge clk);
            if (c < W) begin
                checks++;
                if ({ovf5, bcd5} !== prev) begin
                    errors++;
                    $display("FAIL hold_stable c=%0d got %h want %h", c, {ovf5, bcd5}, prev);
                end
            end else begin
                checks++;
                if (done5 !== 1'b1 || q5.size() == 0) begin
                    errors++;
                    $display("FAIL hold_done got %b want 1", done5);
                end else begin
                    e = q5.pop_front();
                    checks++;
                    if ({ovf5, bcd5} !== e) begin
                        errors++;
                        $display("FAIL hold_result got %h want %h", {ovf5, bcd5}, e);
                    end
                end
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow4();
        test_ignore_start();
        test_reset_abort();
        test_hold();
        checks++;
        if (q5.size() != 0 || q4.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d/%0d pending want 0/0", q5.size(), q4.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
